cheri_dmem_responder: RTL and testbench



---
 rtl/cheri_dmem_responder.sv | 146 ++++++++++++++
 tb/tb_cheri_dmem_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheri_dmem_responder.sv
// cheri_dmem_responder
// Memory-side responder for the core's data bus. It holds a word array with a
// CHERI tag bit per word, grants requests in the same cycle, and answers in
// order after a fixed latency. Tags are set only by capability stores, are
// cleared by plain stores, and are hidden from plain loads.
//
// Optional feature: define CHERI_DMEM_CAP_ALIGN_CHK_EN to make a capability
// access with partial byte enables return an error. An erroring write does not
// commit and an erroring read returns 0. When the macro is undefined, partial
// capability writes go ahead, and they also update the tag.
module cheri_dmem_responder #(
   parameter logic [31:0] AddrBase       = 32'h2000_0000,
   parameter int          NWords         = 4096,
   parameter int          Latency        = 1,
   parameter int          MaxOutstanding = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   input  logic        data_is_cap_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [32:0] data_wdata_i,
   input  logic        stall_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [32:0] data_rdata_o,
   output logic        data_err_o
);

   localparam int IdxW = $clog2(NWords);
   localparam int CntW = $clog2(MaxOutstanding + 1);

   logic [31:0]       mem [NWords];
   logic [NWords-1:0] tags;

   logic [CntW-1:0]   outstanding;
   logic [CntW-1:0]   occupied;

   logic              pipe_valid [Latency];
   logic              pipe_err   [Latency];
   logic [32:0]       pipe_rdata [Latency];

   logic [31:0]       word_off;
   logic              in_range;
   logic [IdxW-1:0]   idx;
   logic              align_err;
   logic              req_err;
   logic [31:0]       rd_word;
   logic              rd_tag;
   logic [32:0]       resp_rdata;
   logic              wr_commit;

   // Address decode and the error decision for the current request.
   always_comb begin
      word_off = (data_addr_i - AddrBase) >> 2;
      in_range = (data_addr_i >= AddrBase) && (word_off < 32'(NWords));
      idx      = word_off[IdxW-1:0];
`ifdef CHERI_DMEM_CAP_ALIGN_CHK_EN
      align_err = data_is_cap_i && (data_be_i != 4'hF);
`else
      align_err = 1'b0;
`endif
      req_err = !in_range || align_err;
   end

   // Grant logic. A response that is being delivered in this cycle frees its
   // slot right away. This lets MaxOutstanding == Latency sustain one request
   // per cycle.
   always_comb begin
      occupied   = outstanding - CntW'(data_rvalid_o);
      data_gnt_o = data_req_i && !stall_i && !rst_i &&
                   (occupied < CntW'(MaxOutstanding));
   end

   // Read the array during the acceptance cycle, so a read sees the value from
   // before any write that commits on the same clock edge.
   always_comb begin
      rd_word    = mem[idx];
      rd_tag     = tags[idx];
      resp_rdata = '0;
      if (!data_we_i && !req_err) begin
         resp_rdata = {rd_tag & data_is_cap_i, rd_word};
      end
      wr_commit = data_gnt_o && data_we_i && !req_err;
   end

   // Data lanes are written byte by byte. The contents are not reset.
   always_ff @(posedge clk_i) begin
      if (wr_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (data_be_i[i]) begin
               mem[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Tag update. A capability store writes the tag, a plain store clears it,
   // and a store with no byte enables leaves the tag as it is.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tags <= '0;
      end else if (wr_commit && (data_be_i != 4'h0)) begin
         tags[idx] <= data_is_cap_i ? data_wdata_i[32] : 1'b0;
      end
   end

   // Response shift register. An accepted request enters stage 0, and the
   // last stage drives the bus.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < Latency; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_err[i]   <= 1'b0;
            pipe_rdata[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= data_gnt_o;
         pipe_err[0]   <= data_gnt_o && req_err;
         pipe_rdata[0] <= data_gnt_o ? resp_rdata : 33'h0;
         for (int i = 1; i < Latency; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_rdata[i] <= pipe_rdata[i-1];
         end
      end
   end

   // Count of requests that are granted but not yet answered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outstanding <= '0;
      end else if (data_gnt_o && !data_rvalid_o) begin
         outstanding <= outstanding + CntW'(1);
      end else if (!data_gnt_o && data_rvalid_o) begin
         outstanding <= outstanding - CntW'(1);
      end
   end

   assign data_rvalid_o = pipe_valid[Latency-1];
   assign data_err_o    = pipe_err[Latency-1];
   assign data_rdata_o  = pipe_rdata[Latency-1];

endmodule

// File: tb/tb_cheri_dmem_responder.sv
// Testbench for cheri_dmem_responder. It uses three instances:
//   a: Latency 1, MaxOutstanding 1. Covers the directed cases and random
//      traffic against a behavioural model.
//   b: Latency 3, MaxOutstanding 2. Covers the throughput and ordering pattern.
//   c: Latency 2, MaxOutstanding 2. Covers stall and mid-flight reset.
module tb_cheri_dmem_responder;
   localparam logic [31:0] BASE  = 32'h2000_0000;
   localparam int          NW    = 4096;
   localparam int          LAT_A = 1;

   logic        clk = 1'b0;
   logic        rst, rst_c, stall, is_cap, we, req_a, req_b, req_c;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [32:0] wdata;
   logic        gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b, gnt_c, rvalid_c, err_c;
   logic [32:0] rdata_a, rdata_b, rdata_c;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cheri_dmem_responder #(.AddrBase(BASE), .NWords(NW), .Latency(1), .MaxOutstanding(1)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .data_req_i(req_a), .data_is_cap_i(is_cap), .data_we_i(we),
      .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .stall_i(stall),
      .data_gnt_o(gnt_a), .data_rvalid_o(rvalid_a), .data_rdata_o(rdata_a), .data_err_o(err_a));

   cheri_dmem_responder #(.AddrBase(BASE), .NWords(NW), .Latency(3), .MaxOutstanding(2)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .data_req_i(req_b), .data_is_cap_i(is_cap), .data_we_i(we),
      .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .stall_i(stall),
      .data_gnt_o(gnt_b), .data_rvalid_o(rvalid_b), .data_rdata_o(rdata_b), .data_err_o(err_b));

   cheri_dmem_responder #(.AddrBase(BASE), .NWords(NW), .Latency(2), .MaxOutstanding(2)) u_dut_c (
      .clk_i(clk), .rst_i(rst_c), .data_req_i(req_c), .data_is_cap_i(is_cap), .data_we_i(we),
      .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .stall_i(stall),
      .data_gnt_o(gnt_c), .data_rvalid_o(rvalid_c), .data_rdata_o(rdata_c), .data_err_o(err_c));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural model of instance a: a word array plus a tag array.
   typedef struct {
      int          due;
      logic        err;
      logic [32:0] rdata;
   } resp_t;

   logic [31:0] mem_m [NW];
   logic        tag_m [NW];
   resp_t       exp_q [$];
   resp_t       got;

   function automatic resp_t model_access(input logic w, input logic c, input logic [3:0] b,
                                          input logic [31:0] a, input logic [32:0] d);
      resp_t r;
      int    k;
      logic  e;
      r.due   = 0;
      r.rdata = '0;
      e = (longint'(a) < longint'(BASE)) || (longint'(a) >= longint'(BASE) + 4 * NW);
`ifdef CHERI_DMEM_CAP_ALIGN_CHK_EN
      if (c && b != 4'hF) e = 1'b1;
`endif
      r.err = e;
      if (!e) begin
         k = int'((longint'(a) - longint'(BASE)) / 4);
         if (!w) begin
            r.rdata = {tag_m[k] & c, mem_m[k]};
         end else if (b != 4'h0) begin
            for (int l = 0; l < 4; l++) begin
               if (b[l]) mem_m[k][8*l +: 8] = d[8*l +: 8];
            end
            tag_m[k] = c ? d[32] : 1'b0;
         end
      end
      return r;
   endfunction

   // Scoreboard for instance a. Each grant queues an expected response, and
   // each rvalid must match the oldest entry, in the right cycle.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < NW; i++) tag_m[i] = 1'b0;
      end else begin
         if (rvalid_a) begin
            if (exp_q.size() == 0) begin
               check("a_unexpected_rvalid", 64'(rvalid_a), 64'd0);
            end else begin
               got = exp_q.pop_front();
               check("a_resp_cycle", 64'(cyc), 64'(got.due));
               check("a_err", 64'(err_a), 64'(got.err));
               check("a_rdata", 64'(rdata_a), 64'(got.rdata));
            end
         end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            check("a_missing_rvalid", 64'(rvalid_a), 64'd1);
            exp_q.delete(0);
         end
         if (gnt_a) begin
            got     = model_access(we, is_cap, be, addr, wdata);
            got.due = cyc + LAT_A;
            exp_q.push_back(got);
         end
      end
   end

   // Drive one request on instance a and hold it until it is granted.
   task automatic issue(input logic w, input logic c, input logic [3:0] b, input logic [31:0] a,
                        input logic [32:0] d, input int stall_pct);
      int n;
      we = w; is_cap = c; be = b; addr = a; wdata = d; req_a = 1'b1;
      stall = (int'($urandom_range(99)) < stall_pct);
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (gnt_a) break;
         @(posedge clk); #1;
         stall = (int'($urandom_range(99)) < stall_pct);
      end
      if (n == 50) check("a_gnt_timeout", 64'(gnt_a), 64'd1);
      @(posedge clk); #1;
      req_a = 1'b0;
      stall = 1'b0;
   endtask

   task automatic xfer(input logic w, input logic c, input logic [3:0] b, input logic [31:0] a,
                       input logic [32:0] d, output logic [32:0] rd, output logic e);
      int n;
      issue(w, c, b, a, d, 0);
      rd = '1;
      e  = 1'bx;
      for (n = 0; n < 10; n++) begin
         if (rvalid_a) break;
         @(posedge clk); #1;
      end
      if (n == 10) begin
         check("a_xfer_timeout", 64'(rvalid_a), 64'd1);
      end else begin
         rd = rdata_a;
         e  = err_a;
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_c(output logic [32:0] rd, output logic e, output int lat);
      int n;
      rd = '1;
      e  = 1'bx;
      for (n = 0; n < 10; n++) begin
         if (rvalid_c) break;
         @(posedge clk); #1;
      end
      lat = n;
      if (n == 10) begin
         check("c_rvalid_timeout", 64'(rvalid_c), 64'd1);
      end else begin
         rd = rdata_c;
         e  = err_c;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [32:0] rd;
      logic        e;
      logic        seen;
      int          lat;
      int          gexp [10] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
      int          rexp [10] = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 0};
      int          k, j, outs, maxo;
      logic [31:0] ra;

      rst = 1'b1; rst_c = 1'b1; stall = 1'b0; is_cap = 1'b0; we = 1'b0;
      req_a = 1'b1; req_b = 1'b0; req_c = 1'b0; be = 4'hF; addr = BASE; wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 64'(gnt_a), 64'd0);
      check("rst_rvalid", 64'(rvalid_a), 64'd0);
      check("rst_rdata", 64'(rdata_a), 64'd0);
      check("rst_err", 64'(err_a), 64'd0);
      @(posedge clk); #1;
      req_a = 1'b0; rst = 1'b0; rst_c = 1'b0;
      @(posedge clk); #1;

      // Directed cases on instance a
      xfer(1, 0, 4'hF, 32'h2000_0010, 33'h0_DEAD_BEEF, rd, e);
      check("tp_wr_err", 64'(e), 64'd0);
      check("tp_wr_rdata", 64'(rd), 64'd0);
      xfer(0, 0, 4'hF, 32'h2000_0010, 33'h0, rd, e);
      check("tp_rd_data", 64'(rd), 64'h0_DEAD_BEEF);
      check("tp_rd_err", 64'(e), 64'd0);

      xfer(1, 1, 4'hF, 32'h2000_0020, 33'h1_1234_5678, rd, e);
      xfer(0, 1, 4'hF, 32'h2000_0020, 33'h0, rd, e);
      check("tag_cap_rd", 64'(rd), 64'h1_1234_5678);
      xfer(0, 0, 4'hF, 32'h2000_0020, 33'h0, rd, e);
      check("tag_plain_rd", 64'(rd), 64'h0_1234_5678);
      xfer(1, 0, 4'b0001, 32'h2000_0020, 33'h0_0000_00AA, rd, e);
      xfer(0, 1, 4'hF, 32'h2000_0020, 33'h0, rd, e);
      check("tag_cleared_rd", 64'(rd), 64'h0_1234_56AA);

      xfer(0, 0, 4'hF, 32'h1FFF_FFFC, 33'h0, rd, e);
      check("oor_rd_err", 64'(e), 64'd1);
      check("oor_rd_data", 64'(rd), 64'd0);
      xfer(1, 0, 4'hF, BASE, 33'h0_55AA_55AA, rd, e);
      xfer(1, 0, 4'hF, 32'h2000_4000, 33'h0_FFFF_FFFF, rd, e);
      check("oor_wr_err", 64'(e), 64'd1);
      xfer(0, 0, 4'hF, BASE, 33'h0, rd, e);
      check("oor_base_unchanged", 64'(rd), 64'h0_55AA_55AA);

      xfer(1, 0, 4'h0, 32'h2000_0010, 33'h0_0000_0111, rd, e);
      check("be0_wr_err", 64'(e), 64'd0);
      xfer(0, 0, 4'hF, 32'h2000_0010, 33'h0, rd, e);
      check("be0_unchanged", 64'(rd), 64'h0_DEAD_BEEF);

      xfer(1, 1, 4'hF, 32'h2000_0030, 33'h1_AAAA_AAAA, rd, e);
      xfer(1, 1, 4'b0011, 32'h2000_0030, 33'h0_1234_5678, rd, e);
`ifdef CHERI_DMEM_CAP_ALIGN_CHK_EN
      check("align_wr_err", 64'(e), 64'd1);
      xfer(0, 1, 4'hF, 32'h2000_0030, 33'h0, rd, e);
      check("align_rd_data", 64'(rd), 64'h1_AAAA_AAAA);
`else
      check("align_wr_err", 64'(e), 64'd0);
      xfer(0, 1, 4'hF, 32'h2000_0030, 33'h0, rd, e);
      check("align_rd_data", 64'(rd), 64'h0_AAAA_5678);
`endif

      // Random traffic on instance a, checked by the scoreboard
      issue(1, 1, 4'hF, BASE + 32'(4 * NW - 4), {1'($urandom), 32'($urandom)}, 0);
      for (int i = 0; i < 16; i++) begin
         issue(1, 1, 4'hF, BASE + 32'h100 + 32'(4 * i), {1'($urandom), 32'($urandom)}, 0);
      end
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(9) == 0) begin
            case ($urandom_range(3))
               0: ra = BASE - 32'd4;
               1: ra = BASE + 32'(4 * NW);
               2: ra = BASE + 32'(4 * NW - 4);
               default: ra = 32'h0000_0000;
            endcase
         end else begin
            ra = BASE + 32'h100 + 32'(4 * $urandom_range(15));
         end
         ra = ra | 32'($urandom_range(3));
         issue(1'($urandom), 1'($urandom), 4'($urandom), ra, {1'($urandom), 32'($urandom)}, 25);
      end
      repeat (3) @(posedge clk);
      #1;
      check("a_queue_drained", 64'(exp_q.size()), 64'd0);

      // Throughput and ordering on instance b
      we = 1'b0; is_cap = 1'b0; be = 4'hF; wdata = '0;
      k = 0; j = 0; outs = 0; maxo = 0;
      for (int c = 0; c < 10; c++) begin
         req_b = (k < 4);
         addr  = (k % 2 == 0) ? BASE + 32'(k * 4) : 32'h1000_0000;
         @(negedge clk);
         check("b_gnt", 64'(gnt_b), 64'(gexp[c]));
         check("b_rvalid", 64'(rvalid_b), 64'(rexp[c]));
         if (rvalid_b) begin
            check("b_err_order", 64'(err_b), 64'(j % 2));
            if (j % 2 == 1) check("b_err_rdata", 64'(rdata_b), 64'd0);
            j++;
         end
         if (gnt_b) k++;
         outs += int'(gnt_b) - int'(rvalid_b);
         if (outs > maxo) maxo = outs;
         @(posedge clk); #1;
      end
      req_b = 1'b0;
      check("b_max_outstanding", 64'(maxo), 64'd2);
      check("b_resp_count", 64'(j), 64'd4);

      // Stall, then reset while a response is in flight, on instance c
      req_c = 1'b1; we = 1'b1; is_cap = 1'b1; be = 4'hF; addr = BASE + 32'h40;
      wdata = 33'h1_CAFE_F00D; stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("c_stall_no_gnt", 64'(gnt_c), 64'd0);
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(negedge clk);
      check("c_gnt_after_release", 64'(gnt_c), 64'd1);
      @(posedge clk); #1;
      req_c = 1'b0;
      wait_c(rd, e, lat);
      check("c_wr_latency", 64'(lat), 64'd1);
      check("c_wr_err", 64'(e), 64'd0);

      we = 1'b0; req_c = 1'b1;
      @(negedge clk);
      check("c_rd_gnt", 64'(gnt_c), 64'd1);
      @(posedge clk); #1;
      req_c = 1'b0; rst_c = 1'b1;
      @(negedge clk);
      seen = rvalid_c;
      check("c_rst_rdata", 64'(rdata_c), 64'd0);
      @(posedge clk); #1;
      rst_c = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | rvalid_c;
         @(posedge clk); #1;
      end
      check("c_dropped_resp", 64'(seen), 64'd0);
      req_c = 1'b1;
      @(negedge clk);
      check("c_rd2_gnt", 64'(gnt_c), 64'd1);
      @(posedge clk); #1;
      req_c = 1'b0;
      wait_c(rd, e, lat);
      check("c_tag_cleared", 64'(rd), 64'h0_CAFE_F00D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
